ifetch: RTL and testbench
=========================

Name: ifetch

Overview:
- Instruction-fetch stage of the veriRISCV 5-stage core, directly upstream of the decode stage.
- Owns the architectural PC and issues word reads on a pipelined, Avalon-style instruction bus, with at most one request outstanding.
- Drives the IF/ID pipeline register (valid, pc, instruction, misaligned-fetch exception).
- Handles stalls with a one-entry skid buffer, and handles redirects (branch/jump/trap/mret) by discarding stale in-flight responses.

Parameters:
RESET_PC, 32'h00000000, PC of the first fetch after reset (must be word-aligned)
NOP_INSTR, 32'h00000013, instruction value driven alongside an exception entry

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-high reset
if_stall  input  1  from HDU; hold IF/ID outputs this cycle
if_redirect  input  1  from EX/MEM/trap logic; discard the current fetch stream
if_redirect_pc  input  32  new PC, valid with if_redirect
ibus_read  output  1  read request
ibus_address  output  32  word address of the request
ibus_waitrequest  input  1  bus not accepting; request accepted when ibus_read & ~ibus_waitrequest
ibus_readdatavalid  input  1  response valid; responses return in order, earliest one cycle after acceptance
ibus_readdata  input  32  instruction word
if2id_valid  output  1  IF/ID entry valid
if2id_pc  output  32  PC of the entry
if2id_instruction  output  32  fetched instruction
if2id_exc_instr_misaligned  output  1  entry carries an instruction-address-misaligned exception

Behaviour:
- Reset (async assert, sync release):
  - if2id_valid = 0, if2id_pc = 0, if2id_instruction = 0, exception flag = 0.
  - Skid buffer empty; pc = RESET_PC; state = REQ.
  - ibus_read = 0 while rst is high.
  - A redirect, bus handshake or stall in the cycle rst deasserts is ignored.
- States:
  - REQ: ibus_read = 1, ibus_address = pc. On acceptance: pc <= pc+4, go to WAIT.
  - WAIT: no request. On readdatavalid, deliver {pc_of_req, ibus_readdata}.
    - If not stalled and the skid buffer is empty, issue the next request in the same cycle (ibus_read = 1, address = pc). This gives 1 instr/cycle on a zero-wait bus.
    - Otherwise go to REQ once the stall and skid buffer clear.
  - DROP_REQ: stale request not yet accepted. Keep ibus_read = 1 with the old address (address must stay stable while waitrequest). On acceptance go to DROP_WAIT.
  - DROP_WAIT: wait for the stale readdatavalid, discard the data, go to REQ (or DROP_REQ if another redirect arrives).
  - HALT: no requests; entered after a misaligned redirect; left only by a redirect.
- Delivery to IF/ID:
  - Not stalled: if2id regs <= skid entry if the skid buffer is full (skid cleared), else the bus response if one arrived, else if2id_valid <= 0.
  - Stalled: if2id regs hold; an arriving response is written to the skid buffer.
  - No new request is accepted into REQ/WAIT issue while the skid buffer is full (max 2 fetched-undelivered entries).
- Redirect (priority over stall and delivery):
  - Next cycle: if2id_valid = 0 and skid cleared.
  - PC update:
    - Aligned target: pc <= if_redirect_pc.
    - Misaligned target (if_redirect_pc[1:0] != 0): pc <= if_redirect_pc and go to HALT.
  - Outstanding request handling:
    - If a request is outstanding (WAIT, or accepted this cycle), go to DROP_WAIT.
    - If a request is pending unaccepted (REQ with waitrequest), go to DROP_REQ.
    - Otherwise go to REQ.
    - A response arriving in the redirect cycle itself is discarded.
- Misaligned exception entry:
  - In HALT, the first non-stalled cycle loads if2id_valid = 1, pc = target, instruction = NOP_INSTR, exc = 1. Afterwards valid = 0.
  - The exception is raised once, without a bus access.
- PC arithmetic: 32-bit, wraps 32'hFFFFFFFC -> 32'h00000000 silently.
- Simultaneous events:
  - redirect + readdatavalid: data dropped.
  - redirect + stall: redirect wins.
  - stall + readdatavalid with the skid buffer full: cannot occur by construction; assertion required.

Test Plan:
- Reset release, zero-wait bus returning mem[a] = a+0x100 -> addresses 0x0, 0x4, 0x8 on consecutive cycles; if2id shows pc 0x0 with instr 0x100 from cycle 2, then one entry per cycle.
- Stall for 3 cycles while a response arrives -> if2id holds pc 0x4; on release delivers pc 0x8 from the skid buffer, then 0xC; no duplicate or lost PC.
- waitrequest high for 2 cycles at 0x10 -> ibus_address stable at 0x10; if2id_valid = 0 for those cycles; fetch resumes normally.
- Redirect to 0x200 while the 0x14 request is outstanding with a 3-cycle latency -> the 0x14 response is discarded; next request 0x200; first valid entry pc 0x200.
- Redirect to 0x202 -> no bus read; a single if2id entry with pc 0x202, instr 0x00000013, exc = 1; then idle until redirect to 0x300 resumes fetching.
- Reset asserted mid-WAIT -> outputs are 0 immediately (asynchronously); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage: PC, single-outstanding ibus reads, IF/ID register with skid
module ifetch #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall,
    input  logic        if_redirect,
    input  logic [31:0] if_redirect_pc,
    output logic        ibus_read,
    output logic [31:0] ibus_address,
    input  logic        ibus_waitrequest,
    input  logic        ibus_readdatavalid,
    input  logic [31:0] ibus_readdata,
    output logic        if2id_valid,
    output logic [31:0] if2id_pc,
    output logic [31:0] if2id_instruction,
    output logic        if2id_exc_instr_misaligned
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_DROP_REQ,
        S_DROP_WAIT,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic        skid_valid;
    logic        exc_pending;
    logic        accept;
    logic        rsp_live;
    logic        redirect_misaligned;

    assign rsp_live            = (state == S_WAIT) && ibus_readdatavalid;
    assign redirect_misaligned = (if_redirect_pc[1:0] != 2'b00);

    always_comb begin
        ibus_read    = 1'b0;
        ibus_address = pc;
        state_nxt    = state;

        // A full skid buffer blocks new fetches so at most two entries are ever undelivered.
        case (state)
            S_REQ:      ibus_read = ~skid_valid;
            S_WAIT:     ibus_read = ibus_readdatavalid & ~if_stall & ~skid_valid;
            S_DROP_REQ: begin
                ibus_read    = 1'b1;
                ibus_address = req_pc;
            end
            default:    ibus_read = 1'b0;
        endcase
        if (rst) begin
            ibus_read = 1'b0;
        end
        accept = ibus_read & ~ibus_waitrequest;

        case (state)
            S_REQ:       if (accept) state_nxt = S_WAIT;
            S_WAIT:      if (ibus_readdatavalid) state_nxt = accept ? S_WAIT : S_REQ;
            S_DROP_REQ:  if (accept) state_nxt = S_DROP_WAIT;
            S_DROP_WAIT: if (ibus_readdatavalid) state_nxt = S_REQ;
            S_HALT:      state_nxt = S_HALT;
            default:     state_nxt = S_REQ;
        endcase

        if (if_redirect) begin
            if (redirect_misaligned) begin
                state_nxt = S_HALT;
            end else if ((((state == S_WAIT) || (state == S_DROP_WAIT)) && !ibus_readdatavalid) || accept) begin
                state_nxt = S_DROP_WAIT;
            end else if (ibus_read) begin
                state_nxt = S_DROP_REQ;
            end else begin
                state_nxt = S_REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                      <= S_REQ;
            pc                         <= RESET_PC;
            req_pc                     <= 32'h0;
            skid_valid                 <= 1'b0;
            skid_pc                    <= 32'h0;
            skid_instr                 <= 32'h0;
            exc_pending                <= 1'b0;
            if2id_valid                <= 1'b0;
            if2id_pc                   <= 32'h0;
            if2id_instruction          <= 32'h0;
            if2id_exc_instr_misaligned <= 1'b0;
        end else begin
            state <= state_nxt;
            // Remember the address of every issued request: it tags the response and
            // keeps the bus address stable if a redirect lands while it is still pending.
            if (ibus_read && (state != S_DROP_REQ)) begin
                req_pc <= pc;
            end
            if (if_redirect) begin
                pc          <= if_redirect_pc;
                if2id_valid <= 1'b0;
                skid_valid  <= 1'b0;
                exc_pending <= redirect_misaligned;
            end else begin
                if (accept && (state != S_DROP_REQ)) begin
                    pc <= pc + 32'd4;
                end
                if (!if_stall) begin
                    if (skid_valid) begin
                        if2id_valid                <= 1'b1;
                        if2id_pc                   <= skid_pc;
                        if2id_instruction          <= skid_instr;
                        if2id_exc_instr_misaligned <= 1'b0;
                        skid_valid                 <= 1'b0;
                    end else if ((state == S_HALT) && exc_pending) begin
                        if2id_valid                <= 1'b1;
                        if2id_pc                   <= pc;
                        if2id_instruction          <= NOP_INSTR;
                        if2id_exc_instr_misaligned <= 1'b1;
                        exc_pending                <= 1'b0;
                    end else if (rsp_live) begin
                        if2id_valid                <= 1'b1;
                        if2id_pc                   <= req_pc;
                        if2id_instruction          <= ibus_readdata;
                        if2id_exc_instr_misaligned <= 1'b0;
                    end else begin
                        if2id_valid <= 1'b0;
                    end
                end else if (rsp_live) begin
                    skid_valid <= 1'b1;
                    skid_pc    <= req_pc;
                    skid_instr <= ibus_readdata;
                end
            end
        end
    end

    a_no_skid_overflow: assert property (@(posedge clk) disable iff (rst)
        !(if_stall && !if_redirect && rsp_live && skid_valid));

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - scoreboard bench for ifetch with a modelled pipelined instruction bus
module tb_ifetch;

    logic        clk;
    logic        rst;
    logic        if_stall;
    logic        if_redirect;
    logic [31:0] if_redirect_pc;
    logic        ibus_read;
    logic [31:0] ibus_address;
    logic        ibus_waitrequest;
    logic        ibus_readdatavalid;
    logic [31:0] ibus_readdata;
    logic        if2id_valid;
    logic [31:0] if2id_pc;
    logic [31:0] if2id_instruction;
    logic        if2id_exc_instr_misaligned;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_pc[$];
    logic [31:0] exp_ins[$];
    logic        exp_exc[$];
    int          bus_due[$];
    logic [31:0] bus_data[$];

    ifetch dut (
        .clk                        (clk),
        .rst                        (rst),
        .if_stall                   (if_stall),
        .if_redirect                (if_redirect),
        .if_redirect_pc             (if_redirect_pc),
        .ibus_read                  (ibus_read),
        .ibus_address               (ibus_address),
        .ibus_waitrequest           (ibus_waitrequest),
        .ibus_readdatavalid         (ibus_readdatavalid),
        .ibus_readdata              (ibus_readdata),
        .if2id_valid                (if2id_valid),
        .if2id_pc                   (if2id_pc),
        .if2id_instruction          (if2id_instruction),
        .if2id_exc_instr_misaligned (if2id_exc_instr_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push_addrs(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_addr.push_back(base + 32'(4 * i));
    endtask

    task automatic push_entries(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_pc.push_back(base + 32'(4 * i));
            exp_ins.push_back(base + 32'(4 * i) + 32'h100);
            exp_exc.push_back(1'b0);
        end
    endtask

    task automatic check_neg(input int c);
        if (c == 4 || c == 5)              chk("no_issue_skid_full", {31'h0, ibus_read}, 32'h0);
        if (c == 8 || c == 9)              chk("wait_addr_stable", ibus_read ? ibus_address : 32'hdead, 32'h10);
        if (c == 10 || c == 11 || c == 13) chk("bubble_valid", {31'h0, if2id_valid}, 32'h0);
        if (c >= 19 && c <= 23)            chk("halt_no_read", {31'h0, ibus_read}, 32'h0);
        if (c >= 21 && c <= 23)            chk("halt_idle_valid", {31'h0, if2id_valid}, 32'h0);
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst && ibus_read && !ibus_waitrequest) begin
            bus_due.push_back(cyc + lat);
            bus_data.push_back(ibus_address + 32'h100);
        end
        check_neg(cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Bus-side monitor: every accepted request address against the expected fetch order.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && ibus_read && !ibus_waitrequest) begin
                if (exp_addr.size() == 0) begin
                    chk("unexpected_request", ibus_address, 32'hffffffff);
                end else begin
                    chk("request_addr", ibus_address, exp_addr.pop_front());
                end
            end
        end
    end

    // IF/ID monitor: each newly loaded entry against the scoreboard.
    initial begin
        logic prev_stall;
        logic prev_redirect;
        logic [31:0] wpc;
        logic [31:0] wins;
        logic        wexc;
        prev_stall    = 1'b0;
        prev_redirect = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall    = 1'b0;
                prev_redirect = 1'b0;
            end else begin
                if (if2id_valid && !(prev_stall && !prev_redirect)) begin
                    checks++;
                    if (exp_pc.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_entry: got pc %h want none (cycle %0d)", if2id_pc, cyc);
                    end else begin
                        wpc  = exp_pc.pop_front();
                        wins = exp_ins.pop_front();
                        wexc = exp_exc.pop_front();
                        if (if2id_pc !== wpc || if2id_instruction !== wins || if2id_exc_instr_misaligned !== wexc) begin
                            errors++;
                            $display("FAIL if2id_entry: got pc %h ins %h exc %b want pc %h ins %h exc %b (cycle %0d)",
                                     if2id_pc, if2id_instruction, if2id_exc_instr_misaligned, wpc, wins, wexc, cyc);
                        end
                    end
                end
                prev_stall    = if_stall;
                prev_redirect = if_redirect;
            end
        end
    end

    initial begin
        rst                = 1'b1;
        if_stall           = 1'b0;
        if_redirect        = 1'b0;
        if_redirect_pc     = 32'h0;
        ibus_waitrequest   = 1'b0;
        ibus_readdatavalid = 1'b0;
        ibus_readdata      = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'h0, if2id_valid}, 32'h0);
        chk("rst_pc", if2id_pc, 32'h0);
        chk("rst_instr", if2id_instruction, 32'h0);
        chk("rst_exc", {31'h0, if2id_exc_instr_misaligned}, 32'h0);
        chk("rst_read", {31'h0, ibus_read}, 32'h0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        push_addrs(32'h0, 6);
        push_entries(32'h0, 5);

        while (cyc < 36) begin
            tick();
            if_stall         = (cyc >= 3 && cyc <= 5);
            ibus_waitrequest = (cyc == 8 || cyc == 9);
            lat              = (cyc == 11) ? 3 : 1;
            if_redirect      = (cyc == 12 || cyc == 18 || cyc == 24);
            case (cyc)
                12: begin
                    if_redirect_pc = 32'h200;
                    push_addrs(32'h200, 4);
                    push_entries(32'h200, 2);
                end
                18: begin
                    if_redirect_pc = 32'h202;
                    exp_pc.push_back(32'h202);
                    exp_ins.push_back(32'h00000013);
                    exp_exc.push_back(1'b1);
                end
                24: begin
                    if_redirect_pc = 32'h300;
                    push_addrs(32'h300, 4);
                    push_entries(32'h300, 2);
                end
                default: if_redirect_pc = 32'h0;
            endcase
            if (cyc == 29) begin
                rst = 1'b1;
                #1;
                chk("async_rst_valid", {31'h0, if2id_valid}, 32'h0);
                chk("async_rst_pc", if2id_pc, 32'h0);
                chk("async_rst_read", {31'h0, ibus_read}, 32'h0);
            end
            if (cyc == 31) begin
                rst = 1'b0;
                push_addrs(32'h0, 5);
                push_entries(32'h0, 3);
            end
            if (rst) begin
                bus_due.delete();
                bus_data.delete();
                ibus_readdatavalid = 1'b0;
            end else if (bus_due.size() != 0 && bus_due[0] == cyc) begin
                void'(bus_due.pop_front());
                ibus_readdatavalid = 1'b1;
                ibus_readdata      = bus_data.pop_front();
            end else begin
                ibus_readdatavalid = 1'b0;
                ibus_readdata      = 32'h0;
            end
        end

        chk("addr_queue_drained", exp_addr.size(), 32'h0);
        chk("entry_queue_drained", exp_pc.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
